// File: rtl/segment_receiver_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// segment_receiver_pkg : FSM states and 7-segment code table | Rev 1.0
// ------------------------------------------------------------------
package segment_receiver_pkg;

    localparam int CODE_W = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        DECODE = 3'd4
    } state_t;

    // Active-low segment patterns {g,f,e,d,c,b,a}, indexed by digit value
    localparam logic [CODE_W-1:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage : segment_receiver_pkg
`default_nettype wire

// File: rtl/segment_receiver_seg_decode.sv
`default_nettype none
// ------------------------------------------------------------------
// seg_decode : 7-segment code to hex digit lookup with hit flag | Rev 1.0
// ------------------------------------------------------------------
module seg_decode
    import segment_receiver_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [3:0]        digit_o,
    output logic              hit_o
);

    // Table entries are unique, so at most one iteration matches
    always_comb begin
        digit_o = 4'd0;
        hit_o   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (code_i == SEG_TABLE[i]) begin
                digit_o = 4'(i);
                hit_o   = 1'b1;
            end
        end
    end

endmodule : seg_decode
`default_nettype wire

// File: rtl/segment_receiver.sv
`default_nettype none
// ------------------------------------------------------------------
// segment_receiver : serial 7-segment code receiver and decoder | Rev 1.0
// ------------------------------------------------------------------
module segment_receiver
    import segment_receiver_pkg::*;
#(
    parameter int BIT_CYCLES = 4
)(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    output logic [3:0] number,
    output logic       valid,
    output logic       code_error,
    output logic       frame_error,
    output logic [7:0] error_count
);

    localparam int               CNT_W     = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);

    logic              rx_meta_q, rx_sync_q;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [CODE_W-1:0] shift_q, shift_d;
    logic [3:0]        number_q, number_d;
    logic              valid_q, valid_d;
    logic              cerr_q, cerr_d;
    logic              ferr_q, ferr_d;
    logic [7:0]        errcnt_q, errcnt_d;
    logic [3:0]        dec_digit;
    logic              dec_hit;

    seg_decode u_seg_decode (
        .code_i  (shift_q),
        .digit_o (dec_digit),
        .hit_o   (dec_hit)
    );

    // Synchroniser resets to the idle level so a released reset never looks like a start edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            shift_q  <= '0;
            number_q <= 4'd0;
            valid_q  <= 1'b0;
            cerr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            errcnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            number_q <= number_d;
            valid_q  <= valid_d;
            cerr_q   <= cerr_d;
            ferr_q   <= ferr_d;
            errcnt_q <= errcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        number_d = number_q;
        valid_d  = 1'b0;
        cerr_d   = 1'b0;
        ferr_d   = 1'b0;
        errcnt_d = errcnt_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = rx_sync_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {shift_q[CODE_W-2:0], rx_sync_q};
                    if (bit_q == 3'd6) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                // Result pulses are registered here so they appear during DECODE
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        state_d = DECODE;
                        if (dec_hit) begin
                            number_d = dec_digit;
                            valid_d  = 1'b1;
                        end else begin
                            cerr_d = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        ferr_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DECODE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((cerr_d || ferr_d) && (errcnt_q != 8'hFF)) begin
            errcnt_d = errcnt_q + 8'd1;
        end
    end

    assign number      = number_q;
    assign valid       = valid_q;
    assign code_error  = cerr_q;
    assign frame_error = ferr_q;
    assign error_count = errcnt_q;

endmodule : segment_receiver
`default_nettype wire

// File: doc/segment_receiver.md
SEGMENT_RECEIVER -- requirements
Module: segment_receiver

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 4: clock cycles per serial bit; legal values are even and >= 4.
REQ-002 SHALL have port clock, input, 1 bit: the single system clock; all flops sample on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port rx, input, 1 bit: asynchronous serial line carrying active-low 7-segment codes; the line idles high.
REQ-005 SHALL have port number, output, 4 bits: the last successfully decoded digit 0x0-0xF.
REQ-006 SHALL have port valid, output, 1 bit: one-cycle pulse when number is updated.
REQ-007 SHALL have port code_error, output, 1 bit: one-cycle pulse when a received code is not in the table.
REQ-008 SHALL have port frame_error, output, 1 bit: one-cycle pulse when the stop bit is sampled as 0.
REQ-009 SHALL have port error_count, output, 8 bits: saturating count of code_error plus frame_error events.

Function
REQ-010 SHALL synchronise rx through two flops, and all logic SHALL use only the synchronised value.
REQ-011 Frame format SHALL be: start bit 0, then 7 data bits, then stop bit 1, with each bit lasting BIT_CYCLES cycles.
REQ-012 Data bits SHALL be sent MSB first: code[6] (segment g) down to code[0] (segment a).
REQ-013 The FSM SHALL have the states IDLE, START, DATA, STOP and DECODE.
REQ-014 In IDLE, a synchronised rx of 0 SHALL move the FSM to START and clear the cycle counter.
REQ-015 In START, after BIT_CYCLES/2 cycles rx SHALL be resampled; 0 moves to DATA, and 1 (a glitch) returns to IDLE with no output.
REQ-016 In DATA, one bit SHALL be sampled every BIT_CYCLES cycles and shifted in; after 7 bits the FSM moves to STOP.
REQ-017 In STOP, rx SHALL be sampled BIT_CYCLES cycles after the last data bit.
REQ-018 A stop sample of 1 SHALL move the FSM to DECODE.
REQ-019 A stop sample of 0 SHALL pulse frame_error in the next cycle, leave number unchanged and return to IDLE.
REQ-020 DECODE SHALL last one cycle and map codes to digits as follows: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 0001000->A, 0000011->B, 1000110->C, 0100001->D, 0000110->E, 0001110->F.
REQ-021 A code in the table SHALL update number and pulse valid in the same cycle, one cycle after the stop sample.
REQ-022 A code not in the table SHALL pulse code_error, leave number unchanged and assert no valid.
REQ-023 After DECODE, the FSM SHALL return to IDLE; a new start bit SHALL be accepted from the next cycle.
REQ-024 valid, code_error and frame_error SHALL be mutually exclusive and never high for more than one consecutive cycle.
REQ-025 error_count SHALL increment by 1 per error pulse and hold at 255.
REQ-026 Bit sampling SHALL occur at mid-bit, ±1 cycle, relative to the start-bit falling edge.

Reset
REQ-027 Asserting reset_n low SHALL immediately force: state IDLE, number 0, valid 0, code_error 0, frame_error 0, error_count 0, counters 0, shift register 0, synchroniser flops 1.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no output pulse.
REQ-029 After reset release, the receiver SHALL wait for a fresh high-to-low start edge.

Structure
REQ-030 The shared package SHALL hold the FSM state enum, the 16-entry segment code table and the code width constant (7).
REQ-031 Decode SHALL be done by a combinational sub-module seg_decode, taking a 7-bit code and returning a 4-bit digit plus a hit flag.
REQ-032 The whole design SHALL be synthesisable RTL with no latches.

Verification (BIT_CYCLES=4)
REQ-033 Frames for all 16 codes in order 0-F SHALL each produce one valid pulse with number equal to the index and error_count staying 0.
REQ-034 A frame with code 1111111 SHALL produce one code_error pulse, keep the previous number and raise error_count to 1.
REQ-035 Frame code 0100100 with stop bit 0 SHALL produce one frame_error pulse, no valid, and leave number unchanged.
REQ-036 A 1-cycle low glitch on idle rx SHALL produce no pulses, return to IDLE, and the following good frame 0110000 SHALL yield number=3.
REQ-037 reset_n pulsed low during data bit 4 SHALL zero all outputs; the next frame 0011001 SHALL yield number=4.
REQ-038 300 consecutive invalid frames SHALL leave error_count=255 without wrapping.
